// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : program-counter generator for the instruction fetch unit.
//
// Produces the fetch address and a valid/ready handshake towards the IFU, and
// takes in trap and branch redirects. A small FSM (BOOT / RUN / HALT) gates
// fetching. Misaligned redirect targets are dropped and reported.
//
// Optional feature: define PC_GEN_RAS_EN to compile in a circular
// return-address stack that predicts return targets. It is pushed on accepted
// calls and popped on accepted returns.
//
// Parameters:
//   WIDTH      PC width in bits (>= 8)
//   RESET_VAL  PC loaded by reset
//   RAS_DEPTH  return-address-stack entries (power of 2, >= 2)
//
// Ports:
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   fetch_valid    out  fetch_pc is valid (RUN state only)
//   fetch_ready    in   IFU accepts fetch_pc
//   fetch_pc       out  current PC (driven straight from the PC register)
//   redirect_valid in   resolved taken branch/jump
//   redirect_pc    in   branch/jump target
//   trap_valid     in   exception/interrupt entry
//   trap_pc        in   trap vector (low two bits forced to zero)
//   halt_req       in   level request to freeze fetch
//   pred_call      in   instruction at the accepted fetch_pc is a call
//   pred_ret       in   instruction at the accepted fetch_pc is a return
//   misalign_err   out  one-cycle pulse for a misaligned redirect target
//   halted         out  FSM is in HALT
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = 32'h8000_0000,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] fetch_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic             halt_req,
  input  logic             pred_call,
  input  logic             pred_ret,
  output logic             misalign_err,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] seq_pc_s;
  logic             misalign_err_r;
  logic             accept_s;
  logic             redirect_ok_s;
  logic             redirect_bad_s;
  logic             ras_hit_s;
  logic [WIDTH-1:0] ras_top_s;

  // Instruction addresses are word aligned; anything else is a bad target.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

  assign accept_s       = fetch_valid & fetch_ready;
  assign seq_pc_s       = pc_r + WIDTH'(4);  // wraps modulo 2^WIDTH
  assign redirect_ok_s  = redirect_valid & is_word_aligned(redirect_pc[1:0]);
  assign redirect_bad_s = redirect_valid & ~trap_valid & ~is_word_aligned(redirect_pc[1:0]);

`ifdef PC_GEN_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ras_ptr_r points at the next free slot; the top entry sits just below it.
  logic [WIDTH-1:0] ras_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_r;
  logic [CNT_W-1:0] ras_cnt_r;
  logic             ras_pop_s;
  logic             ras_push_s;

  assign ras_pop_s  = accept_s & pred_ret & (ras_cnt_r != {CNT_W{1'b0}});
  assign ras_push_s = accept_s & pred_call;
  assign ras_hit_s  = ras_pop_s;
  assign ras_top_s  = ras_r[ras_ptr_r - PTR_W'(1)];

  // Return-address stack: circular buffer, oldest entry overwritten when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= {WIDTH{1'b0}};
      end
      ras_ptr_r <= {PTR_W{1'b0}};
      ras_cnt_r <= {CNT_W{1'b0}};
    end else if (ras_pop_s && ras_push_s) begin
      // Coroutine swap: pop then push leaves depth unchanged, top replaced.
      ras_r[ras_ptr_r - PTR_W'(1)] <= seq_pc_s;
    end else if (ras_pop_s) begin
      ras_ptr_r <= ras_ptr_r - PTR_W'(1);
      ras_cnt_r <= ras_cnt_r - CNT_W'(1);
    end else if (ras_push_s) begin
      ras_r[ras_ptr_r] <= seq_pc_s;
      ras_ptr_r        <= ras_ptr_r + PTR_W'(1);
      if (ras_cnt_r != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_r <= ras_cnt_r + CNT_W'(1);
      end else begin
        ras_cnt_r <= ras_cnt_r;
      end
    end else begin
      ras_ptr_r <= ras_ptr_r;
      ras_cnt_r <= ras_cnt_r;
    end
  end
`else
  logic unused_pred_s;

  assign unused_pred_s = pred_call ^ pred_ret;
  assign ras_hit_s     = 1'b0;
  assign ras_top_s     = {WIDTH{1'b0}};
`endif

  // State, PC and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_BOOT;
      pc_r           <= RESET_VAL;
      misalign_err_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_next_s;
      misalign_err_r <= redirect_bad_s;
    end
  end

  // Next-state logic; a trap or good redirect in RUN defers the halt by a cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: state_s = ST_RUN;
      ST_RUN: begin
        if (halt_req && !trap_valid && !redirect_ok_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_BOOT;
    endcase
  end

  // Next-PC selection in priority order; redirects act in every state.
  always_comb begin
    pc_next_s = pc_r;
    if (trap_valid) begin
      pc_next_s = {trap_pc[WIDTH-1:2], 2'b00};
    end else if (redirect_ok_s) begin
      pc_next_s = redirect_pc;
    end else if (ras_hit_s) begin
      pc_next_s = ras_top_s;
    end else if (accept_s) begin
      pc_next_s = seq_pc_s;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Output decode of the state register.
  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state_r)
      ST_RUN:  fetch_valid = 1'b1;
      ST_HALT: halted      = 1'b1;
      default: begin
        fetch_valid = 1'b0;
        halted      = 1'b0;
      end
    endcase
  end

  assign fetch_pc     = pc_r;
  assign misalign_err = misalign_err_r;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halt_req;
  logic        pred_call;
  logic        pred_ret;
  logic        misalign_err;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  pc_gen #(.WIDTH(32), .RESET_VAL(32'h8000_0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .halt_req(halt_req), .pred_call(pred_call), .pred_ret(pred_ret),
    .misalign_err(misalign_err), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
    logic        halt;
    logic        ready;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_halted;
    logic        e_mis;
  } vec_t;

  vec_t tbl[27];

  // Behavioural reference: mode 0=boot 1=run 2=halt, RAS as a queue.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic tv, logic [31:0] tpc,
                              logic halt, logic ready, logic [31:0] e_pc,
                              logic e_valid, logic e_halted, logic e_mis);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.tv = tv; v.tpc = tpc; v.halt = halt; v.ready = ready;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_halted = e_halted; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rv, input logic [31:0] rpc, input logic tv,
                        input logic [31:0] tpc, input logic halt, input logic ready,
                        input logic call, input logic ret);
    redirect_valid = rv; redirect_pc = rpc; trap_valid = tv; trap_pc = tpc;
    halt_req = halt; fetch_ready = ready; pred_call = call; pred_ret = ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RV;
    m_mis  = 1'b0;
    m_ras.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit          acc;
    bit          aligned;
    logic [31:0] seq;
    logic [31:0] tgt;
    acc     = (m_mode == 1) && fetch_ready;
    aligned = (redirect_pc % 4) == 0;
    seq     = m_pc + 32'd4;
    tgt     = seq;
`ifdef PC_GEN_RAS_EN
    if (acc && pred_ret && m_ras.size() > 0) tgt = m_ras.pop_back();
    if (acc && pred_call) begin
      m_ras.push_back(seq);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
`endif
    m_mis = redirect_valid && !trap_valid && !aligned;
    if (trap_valid) m_pc = trap_pc & 32'hFFFF_FFFC;
    else if (redirect_valid && aligned) m_pc = redirect_pc;
    else if (acc) m_pc = tgt;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (halt_req && !trap_valid && !(redirect_valid && aligned)) m_mode = 2;
    end else if (!halt_req) m_mode = 1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, fetch_pc, m_pc);
    chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, m_mode == 1});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == 2});
    chk({tag, ".mis"}, {31'd0, misalign_err}, {31'd0, m_mis});
  endtask

  initial begin
    logic [31:0] exp_ret[5];
    logic [31:0] r;
    logic [31:0] rpc;
    logic        hl;

    // Directed vectors, each row is one clock after reset release.
    tbl[0]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_0000, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_0004, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_0008, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_000C, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_0010, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 32'h8000_0010, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'h8000_0010, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 32'h8000_0010, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_0014, 1, 0, 0);
    tbl[9]  = mk(1, 32'h8000_0200, 1, 32'h8000_0100, 0, 1, 32'h8000_0100, 1, 0, 0);
    tbl[10] = mk(1, 32'h8000_0202, 0, 0, 0, 1, 32'h8000_0104, 1, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 32'h8000_0108, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 32'h8000_010C, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 32'h8000_010C, 0, 1, 0);
    tbl[14] = mk(1, 32'h8000_0300, 0, 0, 1, 1, 32'h8000_0300, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, 1, 32'h8000_0300, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 32'h8000_0300, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 32'h8000_0304, 1, 0, 0);
    tbl[18] = mk(0, 0, 1, 32'h8000_0403, 0, 1, 32'h8000_0400, 1, 0, 0);
    tbl[19] = mk(1, 32'h8000_0501, 0, 0, 0, 0, 32'h8000_0400, 1, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 1, 32'h8000_0404, 1, 0, 0);
    tbl[21] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 0, 0);
    tbl[24] = mk(0, 0, 1, 32'h0000_0200, 1, 1, 32'h0000_0200, 1, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 1, 1, 32'h0000_0204, 0, 1, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 32'h0000_0204, 1, 0, 0);

    // Reset state.
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst.pc", fetch_pc, RV);
    chk("rst.valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.mis", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      set_in(tbl[i].rv, tbl[i].rpc, tbl[i].tv, tbl[i].tpc, tbl[i].halt, tbl[i].ready, 0, 0);
      tick();
      chk($sformatf("tbl%0d.pc", i), fetch_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.valid", i), {31'd0, fetch_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].e_halted});
      chk($sformatf("tbl%0d.mis", i), {31'd0, misalign_err}, {31'd0, tbl[i].e_mis});
    end

    // Call chain: each call is accepted while its target redirect lands.
    set_in(1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ras.start", fetch_pc, 32'h0000_1000);
    for (int k = 1; k <= 5; k++) begin
      set_in(1, (k == 5) ? 32'h0000_9000 : (k + 1) * 32'h1000, 0, 0, 0, 1, 1, 0);
      tick();
      chk($sformatf("call%0d", k), fetch_pc, (k == 5) ? 32'h0000_9000 : (k + 1) * 32'h1000);
    end
`ifdef PC_GEN_RAS_EN
    exp_ret[0] = 32'h5004; exp_ret[1] = 32'h4004; exp_ret[2] = 32'h3004;
    exp_ret[3] = 32'h2004; exp_ret[4] = 32'h2008;
`else
    exp_ret[0] = 32'h9004; exp_ret[1] = 32'h9008; exp_ret[2] = 32'h900C;
    exp_ret[3] = 32'h9010; exp_ret[4] = 32'h9014;
`endif
    for (int j = 0; j < 5; j++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 1);
      tick();
      chk($sformatf("ret%0d", j), fetch_pc, exp_ret[j]);
    end

    // Randomised run against the reference model, with one async reset mid-way.
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    hl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        chk("async_rst.pc", fetch_pc, RV);
        chk("async_rst.valid", {31'd0, fetch_valid}, 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
      end
      if ($urandom_range(0, 39) == 0) hl = ~hl;
      r   = $urandom;
      rpc = {r[31:2], 2'b00};
      if ($urandom_range(0, 3) == 0) rpc[1:0] = r[1:0];
      set_in($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 31) == 0, $urandom,
             hl, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0);
      model_step();
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits (>=8).
REQ-002 SHALL have parameter RESET_VAL, default 32'h8000_0000, PC value loaded by reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port fetch_valid, output, 1, fetch_pc is valid for IFU.
REQ-007 SHALL have port fetch_ready, input, 1, IFU accepts fetch_pc.
REQ-008 SHALL have port fetch_pc, output, WIDTH, current PC.
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump resolved taken.
REQ-010 SHALL have port redirect_pc, input, WIDTH, branch/jump target.
REQ-011 SHALL have port trap_valid, input, 1, exception/interrupt entry.
REQ-012 SHALL have port trap_pc, input, WIDTH, trap vector target.
REQ-013 SHALL have port halt_req, input, 1, level; freeze fetch (ebreak/debug).
REQ-014 SHALL have port pred_call, input, 1, instruction at accepted fetch_pc is a call.
REQ-015 SHALL have port pred_ret, input, 1, instruction at accepted fetch_pc is a return.
REQ-016 SHALL have port misalign_err, output, 1, one-cycle pulse: redirect target not 4-byte aligned.
REQ-017 SHALL have port halted, output, 1, FSM in HALT.

Function
REQ-018 FSM states SHALL be BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT when halt_req=1 and no trap/redirect that cycle; HALT->RUN when halt_req=0.
REQ-019 fetch_valid SHALL be 1 only in RUN; 0 in BOOT and HALT.
REQ-020 Handshake: fetch_pc SHALL hold stable while fetch_valid=1 and fetch_ready=0; advance only on fetch_valid&fetch_ready ("accept").
REQ-021 Next-PC priority SHALL be: trap_valid (trap_pc) > redirect_valid (redirect_pc) > accept&pred_ret&RAS non-empty (top of RAS) > accept (fetch_pc+4) > hold.
REQ-022 trap_valid and aligned redirect_valid SHALL update PC next edge in any state, including HALT and while fetch_ready=0; redirect in HALT keeps state HALT.
REQ-023 redirect_pc[1:0]!=0 with no trap SHALL be ignored (PC follows lower priorities) and SHALL pulse misalign_err next cycle; trap_pc low bits SHALL be forced to 0.
REQ-024 Sequential increment SHALL be modulo 2^WIDTH (all-ones-minus-3 wraps to 0).
REQ-025 pred_call/pred_ret SHALL be ignored unless accept; both asserted SHALL act as pop then push (RISC-V coroutine).
REQ-026 Zero-latency: PC register output drives fetch_pc directly; new PC visible one cycle after the causing edge.
REQ-027 misalign_err SHALL be registered, high exactly one cycle per bad redirect.

Reset
REQ-028 rst=1 SHALL asynchronously set PC=RESET_VAL, state=BOOT, fetch_valid=0, misalign_err=0, halted=0, RAS pointer=0 (empty), count=0.
REQ-029 rst mid-operation SHALL discard pending redirect/trap/RAS contents; first fetch after release SHALL be RESET_VAL, issued on 2nd edge after deassertion.

Configuration
REQ-030 Macro PC_GEN_RAS_EN SHALL compile in the return-address stack.
REQ-031 With PC_GEN_RAS_EN: accept&pred_call SHALL push fetch_pc+4; accept&pred_ret SHALL pop; push when full SHALL overwrite oldest (circular, count saturates at RAS_DEPTH); pop when empty SHALL fall back to fetch_pc+4.
REQ-032 Without PC_GEN_RAS_EN: no RAS storage; pred_call/pred_ret SHALL be ignored; next PC follows REQ-021 with RAS term removed.

Verification
REQ-033 Reset: rst pulse, fetch_ready=1 -> fetch_pc=0x8000_0000, fetch_valid=0 one cycle, then 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-034 Backpressure: fetch_ready=0 for 3 cycles at 0x8000_0010 -> fetch_pc holds 0x8000_0010, then 0x8000_0014 after accept.
REQ-035 Priority: trap_valid=1 (0x8000_0100) and redirect_valid=1 (0x8000_0200) same cycle -> next fetch_pc=0x8000_0100; redirect_pc=0x8000_0202 alone -> misalign_err one cycle, PC increments.
REQ-036 Halt: halt_req=1 -> halted=1, fetch_valid=0, PC frozen; redirect 0x8000_0300 while halted -> PC=0x8000_0300, stays halted; halt_req=0 -> fetches 0x8000_0300.
REQ-037 RAS (PC_GEN_RAS_EN, depth 4): 5 calls at 0x1000,0x2000,0x3000,0x4000,0x5000 then 5 returns -> targets 0x5004,0x4004,0x3004,0x2004, then empty fallback fetch_pc+4.
REQ-038 Wrap: WIDTH=32, PC=0xFFFF_FFFC accepted -> next fetch_pc=0x0000_0000.
